// File: rtl/ram_writer_pkg.sv
// Shared definitions for the RAM stream writer: burst sequencing states.
package ram_writer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } wr_state_e;

endpackage

// File: rtl/ram_stream_writer_wrap_counter.sv
// Loadable address counter that steps by one and wraps depth_p-1 -> 0.
module wrap_counter #(
    parameter int unsigned depth_p = 128
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       load_i,
    input  logic [$clog2(depth_p)-1:0] load_val_i,
    input  logic                       inc_i,
    output logic [$clog2(depth_p)-1:0] value_o
);

    localparam int unsigned AW = $clog2(depth_p);
    localparam logic [AW-1:0] LAST = AW'(depth_p - 1);

    logic [AW-1:0] value_q;
    logic [AW-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = load_val_i;
        end else if (inc_i) begin
            value_d = (value_q == LAST) ? '0 : value_q + AW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/ram_stream_writer.sv
// Accepts a valid/ready word stream and writes a burst of len_i words to an
// external synchronous-write RAM starting at base_addr_i.
module ram_stream_writer
    import ram_writer_pkg::*;
#(
    parameter int unsigned width_p = 8,
    parameter int unsigned depth_p = 128
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       start_i,
    input  logic [$clog2(depth_p)-1:0] base_addr_i,
    input  logic [$clog2(depth_p):0]   len_i,
    input  logic                       valid_i,
    input  logic [width_p-1:0]         data_i,
    output logic                       ready_o,
    output logic                       wr_en_o,
    output logic [$clog2(depth_p)-1:0] wr_addr_o,
    output logic [width_p-1:0]         wr_data_o,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam int unsigned AW = $clog2(depth_p);
    localparam int unsigned CW = AW + 1;

    wr_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    addr;
    logic             xfer;
    logic             load;
    logic             wr_en_q;
    logic [AW-1:0]    wr_addr_q;
    logic [width_p-1:0] wr_data_q;

    assign ready_o = (state_q == WRITE);
    assign xfer    = ready_o & valid_i;
    assign load    = (state_q == IDLE) && start_i && (len_i != '0);

    wrap_counter #(
        .depth_p (depth_p)
    ) u_addr (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .load_i     (load),
        .load_val_i (base_addr_i),
        .inc_i      (xfer),
        .value_o    (addr)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (len_i != '0) begin
                        state_d = WRITE;
                        cnt_d   = len_i;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            WRITE: begin
                if (xfer) begin
                    cnt_d = cnt_q - CW'(1);
                    // Last word: DONE lines up with its registered write strobe.
                    if (cnt_q == CW'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_en_q <= xfer;
            if (xfer) begin
                wr_addr_q <= addr;
                wr_data_q <= data_i;
            end
        end
    end

    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;
    assign busy_o    = (state_q != IDLE);
    assign done_o    = (state_q == DONE);

endmodule

// File: tb/tb_ram_stream_writer.sv
// Directed self-checking bench for ram_stream_writer (width_p=8, depth_p=128).
module tb_ram_stream_writer;

    logic       clk_i = 1'b0;
    logic       reset_n_i;
    logic       start_i;
    logic [6:0] base_addr_i;
    logic [7:0] len_i;
    logic       valid_i;
    logic [7:0] data_i;
    logic       ready_o;
    logic       wr_en_o;
    logic [6:0] wr_addr_o;
    logic [7:0] wr_data_o;
    logic       busy_o;
    logic       done_o;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [6:0]  last_addr = '0;
    logic [7:0]  last_data = '0;

    // {ready, busy, done, wr_en, addr, data}
    logic [18:0] obs;
    assign obs = {ready_o, busy_o, done_o, wr_en_o, wr_addr_o, wr_data_o};

    ram_stream_writer #(
        .width_p (8),
        .depth_p (128)
    ) dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .len_i       (len_i),
        .valid_i     (valid_i),
        .data_i      (data_i),
        .ready_o     (ready_o),
        .wr_en_o     (wr_en_o),
        .wr_addr_o   (wr_addr_o),
        .wr_data_o   (wr_data_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_burst(input string name, input logic [6:0] base,
                             input int unsigned len, input logic [7:0] d0);
        logic [18:0] exp;
        logic [6:0]  a;
        logic [7:0]  d;
        start_i = 1'b1; base_addr_i = base; len_i = 8'(len);
        valid_i = 1'b1; data_i = d0;
        tick();
        start_i = 1'b0;
        exp = {1'b1, 1'b1, 1'b0, 1'b0, last_addr, last_data};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s_enter actual=%h required=%h", name, obs, exp);
        end
        for (int i = 0; i < int'(len); i++) begin
            d = d0 + 8'(i);
            a = base + 7'(i);
            data_i = d;
            tick();
            exp = {(i != int'(len) - 1), 1'b1, (i == int'(len) - 1), 1'b1, a, d};
            last_addr = a; last_data = d;
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL %s_w%0d actual=%h required=%h", name, i, obs, exp);
            end
        end
        valid_i = 1'b0;
        tick();
        exp = {1'b0, 1'b0, 1'b0, 1'b0, last_addr, last_data};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s_idle actual=%h required=%h", name, obs, exp);
        end
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0; start_i = 1'b0; base_addr_i = '0; len_i = '0;
        valid_i = 1'b0; data_i = '0;
        #1;
        n_cmp++;
        if (obs !== 19'h0) begin
            n_bad++;
            $display("FAIL reset_async actual=%h required=%h", obs, 19'h0);
        end
        tick(); tick();
        n_cmp++;
        if (obs !== 19'h0) begin
            n_bad++;
            $display("FAIL reset_held actual=%h required=%h", obs, 19'h0);
        end
        reset_n_i = 1'b1;
        tick();
        n_cmp++;
        if (obs !== 19'h0) begin
            n_bad++;
            $display("FAIL reset_release actual=%h required=%h", obs, 19'h0);
        end
    endtask

    task automatic test_basic();
        run_burst("basic", 7'h10, 4, 8'hA0);
    endtask

    task automatic test_wrap();
        run_burst("wrap", 7'h7E, 4, 8'h50);
        n_cmp++;
        if (last_addr !== 7'h01 || wr_addr_o !== 7'h01) begin
            n_bad++;
            $display("FAIL wrap_final actual=%h required=%h", wr_addr_o, 7'h01);
        end
    endtask

    task automatic test_valid_gaps();
        logic [4:0]  vpat;
        logic [18:0] exp [5];
        vpat = 5'b11001; // bit k = valid in cycle k
        exp[0] = {1'b1, 1'b1, 1'b0, 1'b1, 7'h20, 8'hB0};
        exp[1] = {1'b1, 1'b1, 1'b0, 1'b0, 7'h20, 8'hB0};
        exp[2] = {1'b1, 1'b1, 1'b0, 1'b0, 7'h20, 8'hB0};
        exp[3] = {1'b1, 1'b1, 1'b0, 1'b1, 7'h21, 8'hB3};
        exp[4] = {1'b0, 1'b1, 1'b1, 1'b1, 7'h22, 8'hB4};
        start_i = 1'b1; base_addr_i = 7'h20; len_i = 8'd3; valid_i = 1'b0;
        tick();
        start_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            valid_i = vpat[k];
            data_i  = 8'hB0 + 8'(k);
            tick();
            n_cmp++;
            if (obs !== exp[k]) begin
                n_bad++;
                $display("FAIL gaps_c%0d actual=%h required=%h", k, obs, exp[k]);
            end
        end
        valid_i = 1'b1;
        tick();
        n_cmp++;
        if (obs !== {4'b0000, 7'h22, 8'hB4}) begin
            n_bad++;
            $display("FAIL gaps_idle actual=%h required=%h", obs, {4'b0000, 7'h22, 8'hB4});
        end
        valid_i = 1'b0;
        last_addr = 7'h22; last_data = 8'hB4;
    endtask

    task automatic test_len_zero();
        start_i = 1'b1; base_addr_i = 7'h55; len_i = 8'd0; valid_i = 1'b1; data_i = 8'hEE;
        tick();
        start_i = 1'b0;
        n_cmp++;
        if (obs !== {4'b0110, last_addr, last_data}) begin
            n_bad++;
            $display("FAIL len0_done actual=%h required=%h", obs, {4'b0110, last_addr, last_data});
        end
        tick();
        n_cmp++;
        if (obs !== {4'b0000, last_addr, last_data}) begin
            n_bad++;
            $display("FAIL len0_idle actual=%h required=%h", obs, {4'b0000, last_addr, last_data});
        end
        valid_i = 1'b0;
    endtask

    task automatic test_ignored_start();
        logic [18:0] exp;
        start_i = 1'b1; base_addr_i = 7'h30; len_i = 8'd3; valid_i = 1'b1; data_i = 8'hC0;
        tick();
        // Keep requesting a different burst through WRITE and DONE.
        base_addr_i = 7'h60; len_i = 8'd5;
        for (int i = 0; i < 3; i++) begin
            data_i = 8'hC0 + 8'(i);
            tick();
            exp = {(i != 2), 1'b1, (i == 2), 1'b1, 7'h30 + 7'(i), 8'hC0 + 8'(i)};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL ignore_w%0d actual=%h required=%h", i, obs, exp);
            end
        end
        tick();
        start_i = 1'b0;
        n_cmp++;
        if (obs !== {4'b0000, 7'h32, 8'hC2}) begin
            n_bad++;
            $display("FAIL ignore_idle actual=%h required=%h", obs, {4'b0000, 7'h32, 8'hC2});
        end
        tick();
        n_cmp++;
        if (obs !== {4'b0000, 7'h32, 8'hC2}) begin
            n_bad++;
            $display("FAIL ignore_noqueue actual=%h required=%h", obs, {4'b0000, 7'h32, 8'hC2});
        end
        valid_i = 1'b0;
        last_addr = 7'h32; last_data = 8'hC2;
    endtask

    task automatic test_reset_mid();
        start_i = 1'b1; base_addr_i = 7'h40; len_i = 8'd5; valid_i = 1'b1; data_i = 8'hD0;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            data_i = 8'hD0 + 8'(i);
            tick();
            n_cmp++;
            if (obs !== {4'b1101, 7'h40 + 7'(i), 8'hD0 + 8'(i)}) begin
                n_bad++;
                $display("FAIL rstmid_w%0d actual=%h required=%h", i, obs,
                         {4'b1101, 7'h40 + 7'(i), 8'hD0 + 8'(i)});
            end
        end
        #2;
        reset_n_i = 1'b0;
        #1;
        n_cmp++;
        if (obs !== 19'h0) begin
            n_bad++;
            $display("FAIL rstmid_async actual=%h required=%h", obs, 19'h0);
        end
        tick(); tick();
        reset_n_i = 1'b1;
        tick();
        n_cmp++;
        if (obs !== 19'h0) begin
            n_bad++;
            $display("FAIL rstmid_nowrite actual=%h required=%h", obs, 19'h0);
        end
        valid_i = 1'b0;
        last_addr = '0; last_data = '0;
        run_burst("postrst", 7'h08, 2, 8'hE0);
    endtask

    task automatic test_full_depth();
        run_burst("full", 7'h05, 128, 8'h00);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_valid_gaps();
        test_len_zero();
        test_ignored_start();
        test_reset_mid();
        test_full_depth();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_stream_writer.md
RAM_STREAM_WRITER -- requirements
Module: ram_stream_writer

Interface
REQ-001 SHALL have parameter width_p, default 8, meaning data word width in bits.
REQ-002 SHALL have parameter depth_p, default 128, meaning number of words in the target RAM (power of two).
REQ-003 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n_i  input  1  reset, asynchronous assertion, active-low.
REQ-005 SHALL have port start_i  input  1  one-cycle burst request.
REQ-006 SHALL have port base_addr_i  input  $clog2(depth_p)  first write address, sampled with start_i.
REQ-007 SHALL have port len_i  input  $clog2(depth_p)+1  burst length in words (0..depth_p), sampled with start_i.
REQ-008 SHALL have port valid_i  input  1  data_i holds a word.
REQ-009 SHALL have port data_i  input  width_p  stream word.
REQ-010 SHALL have port ready_o  output  1  block accepts data_i this cycle.
REQ-011 SHALL have port wr_en_o  output  1  RAM write strobe.
REQ-012 SHALL have port wr_addr_o  output  $clog2(depth_p)  RAM write address.
REQ-013 SHALL have port wr_data_o  output  width_p  RAM write data.
REQ-014 SHALL have port busy_o  output  1  burst in progress.
REQ-015 SHALL have port done_o  output  1  one-cycle pulse at burst completion.

Function
REQ-016 SHALL implement FSM states IDLE, WRITE, DONE.
REQ-017 IDLE: start_i=1 with len_i>0 SHALL load address counter with base_addr_i, remaining count with len_i, go to WRITE next cycle.
REQ-018 IDLE: start_i=1 with len_i=0 SHALL go directly to DONE, with no write.
REQ-019 start_i in WRITE or DONE SHALL be ignored; no queuing.
REQ-020 ready_o SHALL be 1 only in WRITE; SHALL be combinational from state only, never from valid_i.
REQ-021 A transfer SHALL occur when valid_i and ready_o are both 1 on a rising edge.
REQ-022 Each transfer SHALL produce, in the following cycle, wr_en_o=1, wr_addr_o=current address, wr_data_o=data_i (one-cycle registered latency).
REQ-023 Without a transfer, wr_en_o SHALL be 0 next cycle; wr_addr_o/wr_data_o SHALL hold their last values.
REQ-024 Address SHALL increment by 1 per transfer, wrapping depth_p-1 -> 0.
REQ-025 Remaining count SHALL decrement by 1 per transfer; the transfer that makes it 0 SHALL move FSM to DONE; ready_o SHALL be 0 from that next cycle.
REQ-026 DONE SHALL last exactly one cycle with done_o=1, then return to IDLE.
REQ-027 busy_o SHALL be 1 in WRITE and DONE, 0 in IDLE.
REQ-028 The final write strobe and done_o SHALL be asserted in the same cycle for len_i>0.
REQ-029 len_i=depth_p SHALL write every address exactly once.

Reset
REQ-030 reset_n_i low SHALL immediately force state IDLE, wr_en_o=0, wr_addr_o=0, wr_data_o=0, ready_o=0, busy_o=0, done_o=0, counters 0.
REQ-031 Reset mid-burst SHALL abandon the burst with no further write strobes; first post-reset start_i SHALL behave as from IDLE.
REQ-032 Reset release SHALL be synchronized outside this block; block assumes clean deassertion.

Structure
REQ-033 FSM state enum SHALL be defined in shared package ram_writer_pkg.
REQ-034 The address counter with wrap SHALL be a sub-module wrap_counter (parameter depth_p; load, increment, value).
REQ-035 Block SHALL contain no memory array; it drives an external synchronous-write RAM.

Verification
REQ-036 base=0x10, len=4, valid_i constant 1, data 0xA0..0xA3 -> wr_en_o 4 consecutive cycles, addr 0x10..0x13, done_o with last write.
REQ-037 base=0x7E, len=4, depth_p=128 -> addresses 0x7E,0x7F,0x00,0x01.
REQ-038 len=3, valid_i toggled 1,0,0,1,1 -> exactly 3 writes, gaps where valid_i=0, correct data order.
REQ-039 start_i with len=0 -> no wr_en_o, done_o one cycle after start, busy_o one cycle.
REQ-040 start_i repeated during WRITE with different base -> ignored; original burst completes unchanged.
REQ-041 reset_n_i low after 2 of 5 transfers -> all outputs 0 immediately, no further writes; new len=2 burst runs correctly.
